cntdiv_prog: RTL and testbench
==============================

Name: cntdiv_prog

Overview:
- Runtime-programmable clock-enable / tick generator; next generation of the fixed power-of-two counter divider.
- Divisor is loaded at run time instead of fixed by a bit-width parameter.
- Provides three outputs:
  - a one-cycle tick pulse;
  - a near-50% duty square output;
  - a one-shot mode with completion flag.
- Sits beside peripheral timing logic (baud, scan, debounce), feeding enables to downstream blocks in the same clock domain.

Parameters:
- WIDTH, 8, width of the divisor and the counter.
- DEFAULT_DIV, 2**WIDTH-1, divisor value after reset; period after reset = DEFAULT_DIV+1 cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserts on falling edge, deasserts synchronously to clk externally).
- en  input  1  count enable; counter holds when low.
- load  input  1  single-cycle request to latch div_in and oneshot_in and restart.
- div_in  input  WIDTH  new divisor D; period = D+1 cycles.
- oneshot_in  input  1  1 = stop after first tick, 0 = free-run.
- tick  output  1  registered one-cycle pulse, once per period.
- sq_out  output  1  registered square wave, high for the upper half of each period.
- done  output  1  one-shot completed; high until next load.
- count  output  WIDTH  current counter value (debug/observe).

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - cnt=0, div_q=DEFAULT_DIV, oneshot_q=0, state=RUN;
  - tick=0, sq_out=0, done=0.
- Internal constant: half = (div_q+1)>>1, computed in WIDTH+1 bits; no overflow when div_q=2**WIDTH-1.

State RUN, each rising edge, in priority order:
1. load=1:
   - div_q<=div_in, oneshot_q<=oneshot_in, cnt<=0, tick<=0, done<=0;
   - sq_out<=(0>=half of new div) — high only if div_in=0.
   - load overrides en in the same cycle.
2. en=0: cnt, sq_out hold; tick<=0.
3. en=1, cnt==div_q (terminal):
   - cnt<=0, tick<=1;
   - if oneshot_q=1, state<=DONE and done<=1.
4. en=1, otherwise: cnt<=cnt+1, tick<=0.
- In cases 3 and 4: sq_out <= (next cnt >= half).

State DONE:
- cnt held at 0; tick=0; sq_out<=0; done=1.
- en is ignored.
- load → RUN with the same actions as RUN case 1.

Timing and boundaries:
- Tick spacing with en held high = div_q+1 cycles.
- First tick after load appears div_q+1 enabled edges after the load edge.
- div_q=0:
  - tick high every enabled cycle; sq_out constant 1 while enabled;
  - one-shot with div 0 ticks once on the first enabled edge.
- Odd period P: sq_out high for (P+1)/2 cycles, low for (P-1)/2.
- Wrap-around: cnt never exceeds div_q. Loading a smaller divisor always restarts at 0, so no stale count above div_q.
- en dropped mid-period: no tick lost or duplicated; counting resumes from the held value.
- Reset mid-period or mid-one-shot: immediate return to reset values, including div_q=DEFAULT_DIV. Any programmed divisor is lost.
- tick and done are never asserted from combinational paths; all outputs come from flops.

Decomposition:
- Package cntdiv_pkg:
  - state typedef enum logic {RUN, DONE};
  - function half_of(div) returning WIDTH+1-bit half-period.
- No sub-module; single always_ff block for counter/state plus registered outputs.

Test Plan:
- Reset then en=1, WIDTH=8, DEFAULT_DIV=255 → first tick on the 256th edge, then every 256 cycles. sq_out low for counts 0..127, high for 128..255.
- load with div_in=3, oneshot_in=0, en=1 → tick every 4 cycles. sq_out pattern 0,0,1,1 repeating; count cycles 0,1,2,3.
- load with div_in=4, en=1 → period 5: sq_out high 3 cycles, low 2; tick once per 5 cycles.
- load with div_in=2, oneshot_in=1, en=1 → exactly one tick 3 edges after load; done=1 from the same edge. No further ticks for 20 cycles; the next load clears done.
- div_in=5, en toggled 1,1,0,0,1,1,1,1 → tick only after the 6th enabled edge; count holds at 2 while en=0. Then load asserted together with en=1 at count=4 → count=0, no tick.
- rst pulsed low mid-count with div=3 → tick, sq_out, done, count go to 0 immediately, asynchronously to clk. Subsequent period returns to DEFAULT_DIV+1.

Source files
------------

// File: rtl/cntdiv_pkg.sv
// Shared types and helpers for the runtime-programmable tick / square-wave divider.
package cntdiv_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Half period (div+1)>>1; one extra bit so an all-ones divisor cannot wrap.
  function automatic logic [32:0] half_of(input logic [31:0] div);
    return ({1'b0, div} + 33'd1) >> 1;
  endfunction

  function automatic logic in_upper_half(input logic [31:0] cnt, input logic [31:0] div);
    return {1'b0, cnt} >= half_of(div);
  endfunction

endpackage

// File: rtl/cntdiv_prog_if.sv
// Control/observe bundle of the programmable divider: master drives controls, slave returns outputs.
interface cntdiv_prog_if #(
  parameter int WIDTH = 8
);
  import cntdiv_pkg::*;

  // No valid/ready pair here: load is a one-cycle strobe sampled on every rising edge
  // (it wins over en), and tick is a one-cycle event the consumer must take when high.
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div_in;
  logic             oneshot_in;
  logic             tick;
  logic             sq_out;
  logic             done;
  logic [WIDTH-1:0] count;
  state_t           state;

  modport master (
    output en, load, div_in, oneshot_in,
    input  tick, sq_out, done, count, state
  );

  modport slave (
    input  en, load, div_in, oneshot_in,
    output tick, sq_out, done, count, state
  );

endinterface

// File: rtl/cntdiv_prog.sv
// Runtime-programmable clock-enable generator: period div+1 ticks, square output, one-shot mode.
module cntdiv_prog
  import cntdiv_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = {WIDTH{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  cntdiv_prog_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             oneshot_q, oneshot_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             done_q, done_d;
  logic             terminal;
  logic [WIDTH-1:0] cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      div_q     <= DEFAULT_DIV;
      oneshot_q <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;
    done_d    = done_q;
    terminal  = (cnt_q == div_q);
    cnt_inc   = terminal ? '0 : cnt_q + WIDTH'(1);

    if (bus.load) begin
      state_d   = RUN;
      div_d     = bus.div_in;
      oneshot_d = bus.oneshot_in;
      cnt_d     = '0;
      done_d    = 1'b0;
      // Count restarts at 0, which sits in the upper half only when the half period is 0.
      sq_d      = (bus.div_in == '0);
    end else begin
      case (state_q)
        RUN: begin
          if (bus.en) begin
            cnt_d  = cnt_inc;
            tick_d = terminal;
            sq_d   = in_upper_half(32'(cnt_inc), 32'(div_q));
            if (terminal && oneshot_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          cnt_d  = '0;
          sq_d   = 1'b0;
          done_d = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.tick   = tick_q;
  assign bus.sq_out = sq_q;
  assign bus.done   = done_q;
  assign bus.count  = cnt_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_cntdiv_prog.sv
// Directed bench for cntdiv_prog: tick timestamps go through a scoreboard, levels are checked inline.
module tb_cntdiv_prog;
  import cntdiv_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cyc = '0;
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  cntdiv_prog_if #(.WIDTH(W)) bus ();

  cntdiv_prog #(.WIDTH(W), .DEFAULT_DIV(8'd255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard: tick timestamps ----------------
  always @(negedge clk) begin
    if (bus.tick === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tick_unexpected: tick at edge %0d, required no tick", cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (e !== cyc) begin
          n_fail++;
          $display("FAIL tick_time: tick at edge %0d, required edge %0d", cyc, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Issued at a negedge; returns the edge number on which the load was taken.
  task automatic do_load(input logic [W-1:0] d, input logic os, output logic [31:0] l);
    bus.load       = 1'b1;
    bus.div_in     = d;
    bus.oneshot_in = os;
    bus.en         = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    l = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] c0;
    logic [31:0] l;
    logic [7:0]  en_pat;
    int          exp_cnt[8];

    en_pat  = 8'b1111_0011;
    exp_cnt = '{1, 2, 2, 2, 3, 4, 5, 0};
    bus.en = 1'b0; bus.load = 1'b0; bus.div_in = '0; bus.oneshot_in = 1'b0;

    step(3);
    check("reset_tick", bus.tick, 0);
    check("reset_sq", bus.sq_out, 0);
    check("reset_done", bus.done, 0);
    check("reset_count", bus.count, 0);
    check("reset_state", bus.state, RUN);
    rst = 1'b1;
    step(3);
    check("idle_count_en0", bus.count, 0);

    // Default divisor 255: period 256, sq high for counts 128..255.
    c0 = cyc;
    exp_q.push_back(c0 + 256);
    exp_q.push_back(c0 + 512);
    bus.en = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      step(1);
      if ((k % 128 == 127) || (k % 128 == 0)) begin
        check("dflt_count", bus.count, k % 256);
        check("dflt_sq", bus.sq_out, ((k % 256) >= 128) ? 1 : 0);
      end
    end

    // div 3: count 0,1,2,3 and sq 0,0,1,1.
    do_load(8'd3, 1'b0, l);
    check("div3_load_count", bus.count, 0);
    exp_q.push_back(l + 4);
    exp_q.push_back(l + 8);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("div3_count", bus.count, k % 4);
      check("div3_sq", bus.sq_out, ((k % 4) >= 2) ? 1 : 0);
    end

    // div 4: period 5, sq high for 3 of 5 cycles.
    do_load(8'd4, 1'b0, l);
    exp_q.push_back(l + 5);
    exp_q.push_back(l + 10);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check("div4_count", bus.count, k % 5);
      check("div4_sq", bus.sq_out, ((k % 5) >= 2) ? 1 : 0);
    end

    // One-shot, div 2: single tick three edges after load, then parked in DONE.
    do_load(8'd2, 1'b1, l);
    exp_q.push_back(l + 3);
    step(2);
    check("os_done_early", bus.done, 0);
    check("os_sq_cnt2", bus.sq_out, 1);
    step(1);
    check("os_done", bus.done, 1);
    check("os_state", bus.state, DONE);
    check("os_count", bus.count, 0);
    for (int k = 0; k < 20; k++) begin
      bus.en = k[0];
      step(1);
    end
    check("os_done_hold", bus.done, 1);
    check("os_sq_low", bus.sq_out, 0);
    check("os_count_hold", bus.count, 0);

    // div 5 with en gaps: count holds at 2, tick after the 6th enabled edge.
    do_load(8'd5, 1'b0, l);
    check("reload_clears_done", bus.done, 0);
    check("reload_state", bus.state, RUN);
    exp_q.push_back(l + 8);
    for (int i = 0; i < 8; i++) begin
      bus.en = en_pat[i];
      step(1);
      check("engap_count", bus.count, exp_cnt[i]);
    end
    bus.en = 1'b1;
    step(4);
    check("engap_count4", bus.count, 4);
    do_load(8'd5, 1'b0, l);
    check("load_over_en_count", bus.count, 0);
    check("load_over_en_tick", bus.tick, 0);

    // div 0: tick every enabled edge, sq constantly high.
    do_load(8'd0, 1'b0, l);
    check("div0_load_sq", bus.sq_out, 1);
    exp_q.push_back(l + 1);
    exp_q.push_back(l + 2);
    exp_q.push_back(l + 3);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("div0_sq", bus.sq_out, 1);
      check("div0_count", bus.count, 0);
    end
    do_load(8'd0, 1'b1, l);
    exp_q.push_back(l + 1);
    step(1);
    check("div0_os_done", bus.done, 1);
    check("div0_os_state", bus.state, DONE);
    step(1);
    check("div0_os_sq", bus.sq_out, 0);

    // Asynchronous reset mid-period restores the default divisor.
    do_load(8'd3, 1'b0, l);
    step(2);
    check("pre_rst_count", bus.count, 2);
    check("pre_rst_sq", bus.sq_out, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", bus.count, 0);
    check("async_rst_sq", bus.sq_out, 0);
    check("async_rst_tick", bus.tick, 0);
    check("async_rst_done", bus.done, 0);
    step(2);
    rst = 1'b1;
    c0 = cyc;
    exp_q.push_back(c0 + 256);
    step(200);
    check("post_rst_count200", bus.count, 200);
    step(60);
    check("post_rst_count4", bus.count, 4);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
